// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX/MEM pipeline register with a valid/ready handshake and a
// two-entry skid buffer (MAIN drives the outputs, SKID absorbs the one beat
// that may arrive while the downstream stage stalls).
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               drop every held beat and the beat offered this cycle
//   valid_i / ready_o     EX-side handshake (ready_o is a flop, not a path from ready_i)
//   WB_i, M_i             write-back / memory control (M bit0 = MemRead, bit1 = MemWrite)
//   RegData_i, MemData_i  ALU result / address and store data
//   RegAddr_i             destination register
//   valid_o / ready_i     MEM-side handshake
//   WB_o, M_o             control of the head beat, forced to 0 on a bubble
//   MemRead_o, MemWrite_o M_o[0], M_o[1]
//   RegData_o, MemData_o, RegAddr_o  payload of the head beat
//   count_o               occupancy 0..2
module ex_mem_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned M_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [DATA_W-1:0] RegData_i,
  input  logic [DATA_W-1:0] MemData_i,
  input  logic [ADDR_W-1:0] RegAddr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [M_W-1:0]    M_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] RegData_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic [ADDR_W-1:0] RegAddr_o,
  output logic [1:0]        count_o
);

  // Encoding equals the occupancy so count_o is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_nxt;

  // MAIN entry: control fields are kept at 0 whenever the slot is empty, so
  // the control outputs need no gating logic after the flops.
  logic [WB_W-1:0]   main_wb_q;
  logic [M_W-1:0]    main_m_q;
  logic [DATA_W-1:0] main_reg_q;
  logic [DATA_W-1:0] main_mem_q;
  logic [ADDR_W-1:0] main_addr_q;

  // SKID entry
  logic [WB_W-1:0]   skid_wb_q;
  logic [M_W-1:0]    skid_m_q;
  logic [DATA_W-1:0] skid_reg_q;
  logic [DATA_W-1:0] skid_mem_q;
  logic [ADDR_W-1:0] skid_addr_q;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic clear_main;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // Next state and entry-load decisions for the handshake path.
  always_comb begin
    state_nxt      = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_main     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = ST_SKID;
        end else if (out_fire) begin
          clear_main = 1'b1;
          state_nxt  = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // ready_o is low here, so no new beat can be accepted.
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = ST_FULL;
        end
      end
      default: begin
        clear_main = 1'b1;
        state_nxt  = ST_EMPTY;
      end
    endcase
  end

  // State, handshake flags and both entries; reset beats flush beats handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      valid_o     <= 1'b0;
      ready_o     <= 1'b1;
      main_wb_q   <= '0;
      main_m_q    <= '0;
      main_reg_q  <= '0;
      main_mem_q  <= '0;
      main_addr_q <= '0;
      skid_wb_q   <= '0;
      skid_m_q    <= '0;
      skid_reg_q  <= '0;
      skid_mem_q  <= '0;
      skid_addr_q <= '0;
    end else if (flush_i) begin
      // Payload is left as is; it is don't-care while valid_o is low.
      state_q   <= ST_EMPTY;
      valid_o   <= 1'b0;
      ready_o   <= 1'b1;
      main_wb_q <= '0;
      main_m_q  <= '0;
      skid_wb_q <= '0;
      skid_m_q  <= '0;
    end else begin
      state_q <= state_nxt;
      valid_o <= (state_nxt != ST_EMPTY);
      ready_o <= (state_nxt != ST_SKID);

      if (load_main_in) begin
        main_wb_q   <= WB_i;
        main_m_q    <= M_i;
        main_reg_q  <= RegData_i;
        main_mem_q  <= MemData_i;
        main_addr_q <= RegAddr_i;
      end else if (load_main_skid) begin
        main_wb_q   <= skid_wb_q;
        main_m_q    <= skid_m_q;
        main_reg_q  <= skid_reg_q;
        main_mem_q  <= skid_mem_q;
        main_addr_q <= skid_addr_q;
      end else if (clear_main) begin
        main_wb_q <= '0;
        main_m_q  <= '0;
      end

      if (load_skid) begin
        skid_wb_q   <= WB_i;
        skid_m_q    <= M_i;
        skid_reg_q  <= RegData_i;
        skid_mem_q  <= MemData_i;
        skid_addr_q <= RegAddr_i;
      end
    end
  end

  assign WB_o       = main_wb_q;
  assign M_o        = main_m_q;
  assign MemRead_o  = main_m_q[0];
  assign MemWrite_o = main_m_q[1];
  assign RegData_o  = main_reg_q;
  assign MemData_o  = main_mem_q;
  assign RegAddr_o  = main_addr_q;
  assign count_o    = state_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg: directed bench for ex_mem_skid_reg. A queue model of the
// two-deep FIFO is checked against the DUT on every falling edge, and literal
// expectations after key steps pin the model itself.
module tb_ex_mem_skid_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WB_W   = 2;
  localparam int unsigned M_W    = 2;

  typedef struct {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] md;
    logic [ADDR_W-1:0] ra;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [WB_W-1:0]   WB_i = '0;
  logic [M_W-1:0]    M_i = '0;
  logic [DATA_W-1:0] RegData_i = '0;
  logic [DATA_W-1:0] MemData_i = '0;
  logic [ADDR_W-1:0] RegAddr_i = '0;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic [WB_W-1:0]   WB_o;
  logic [M_W-1:0]    M_o;
  logic              MemRead_o;
  logic              MemWrite_o;
  logic [DATA_W-1:0] RegData_o;
  logic [DATA_W-1:0] MemData_o;
  logic [ADDR_W-1:0] RegAddr_o;
  logic [1:0]        count_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit en = 1'b0;
  beat_t q[$];

  ex_mem_skid_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_W(WB_W), .M_W(M_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .WB_i(WB_i), .M_i(M_i), .RegData_i(RegData_i), .MemData_i(MemData_i),
    .RegAddr_i(RegAddr_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .WB_o(WB_o), .M_o(M_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .RegData_o(RegData_o), .MemData_o(MemData_o), .RegAddr_o(RegAddr_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO holding at most two beats; ready while fewer than two held.
  always @(posedge clk) begin
    bit m_in_fire;
    bit m_out_fire;
    beat_t b;
    m_in_fire  = valid_i && (q.size() < 2);
    m_out_fire = (q.size() > 0) && ready_i;
    if (rst_i || flush_i) begin
      q.delete();
    end else begin
      if (m_out_fire) void'(q.pop_front());
      if (m_in_fire) begin
        b.wb = WB_i; b.m = M_i; b.rd = RegData_i; b.md = MemData_i; b.ra = RegAddr_i;
        q.push_back(b);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (en) begin
      chk("model valid_o", 64'(valid_o), 64'(q.size() > 0));
      chk("model ready_o", 64'(ready_o), 64'(q.size() < 2));
      chk("model count_o", 64'(count_o), 64'(q.size()));
      if (q.size() > 0) begin
        chk("model WB_o", 64'(WB_o), 64'(q[0].wb));
        chk("model M_o", 64'(M_o), 64'(q[0].m));
        chk("model MemRead_o", 64'(MemRead_o), 64'(q[0].m[0]));
        chk("model MemWrite_o", 64'(MemWrite_o), 64'(q[0].m[1]));
        chk("model RegData_o", 64'(RegData_o), 64'(q[0].rd));
        chk("model MemData_o", 64'(MemData_o), 64'(q[0].md));
        chk("model RegAddr_o", 64'(RegAddr_o), 64'(q[0].ra));
      end else begin
        chk("bubble WB_o", 64'(WB_o), 64'd0);
        chk("bubble M_o", 64'(M_o), 64'd0);
        chk("bubble MemRead_o", 64'(MemRead_o), 64'd0);
        chk("bubble MemWrite_o", 64'(MemWrite_o), 64'd0);
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic step(input logic r, input logic f, input logic v, input logic rdy,
                      input logic [WB_W-1:0] wb, input logic [M_W-1:0] m,
                      input logic [DATA_W-1:0] rd);
    rst_i = r; flush_i = f; valid_i = v; ready_i = rdy;
    WB_i = wb; M_i = m; RegData_i = rd;
    MemData_i = ~rd; RegAddr_i = rd[ADDR_W-1:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] vpat;
    logic [23:0] rpat;

    // T1: reset held with a live beat offered
    step(1, 0, 1, 0, 2'b11, 2'b11, 32'h55);
    step(1, 0, 1, 0, 2'b11, 2'b11, 32'h55);
    en = 1'b1;
    chk("T1 valid_o", 64'(valid_o), 64'd0);
    chk("T1 ready_o", 64'(ready_o), 64'd1);
    chk("T1 count_o", 64'(count_o), 64'd0);
    chk("T1 MemRead_o", 64'(MemRead_o), 64'd0);
    chk("T1 MemWrite_o", 64'(MemWrite_o), 64'd0);
    chk("T1 RegData_o", 64'(RegData_o), 64'd0);

    // T2: back-to-back stream, no backpressure
    step(0, 0, 1, 1, 2'b01, 2'b00, 32'h11);
    chk("T2 beat0", 64'(RegData_o), 64'h11);
    chk("T2 valid0", 64'(valid_o), 64'd1);
    step(0, 0, 1, 1, 2'b01, 2'b00, 32'h22);
    chk("T2 beat1", 64'(RegData_o), 64'h22);
    chk("T2 valid1", 64'(valid_o), 64'd1);
    step(0, 0, 1, 1, 2'b01, 2'b00, 32'h33);
    chk("T2 beat2", 64'(RegData_o), 64'h33);
    chk("T2 valid2", 64'(valid_o), 64'd1);
    step(0, 0, 0, 1, 2'b00, 2'b00, 32'h0);
    chk("T2 drained", 64'(valid_o), 64'd0);

    // T3: backpressure fills the skid entry, C waits upstream
    step(0, 0, 1, 0, 2'b00, 2'b00, 32'hA);
    step(0, 0, 1, 0, 2'b00, 2'b00, 32'hB);
    chk("T3 count", 64'(count_o), 64'd2);
    chk("T3 ready_o", 64'(ready_o), 64'd0);
    chk("T3 head A", 64'(RegData_o), 64'hA);
    step(0, 0, 1, 0, 2'b00, 2'b00, 32'hC);
    chk("T3 A held", 64'(RegData_o), 64'hA);
    chk("T3 count held", 64'(count_o), 64'd2);
    step(0, 0, 1, 1, 2'b00, 2'b00, 32'hC);
    chk("T3 B next", 64'(RegData_o), 64'hB);
    step(0, 0, 1, 1, 2'b00, 2'b00, 32'hC);
    chk("T3 C next", 64'(RegData_o), 64'hC);
    step(0, 0, 0, 1, 2'b00, 2'b00, 32'h0);
    chk("T3 drained", 64'(valid_o), 64'd0);

    // T4: flush while two beats held and 0xD offered
    step(0, 0, 1, 0, 2'b11, 2'b11, 32'h41);
    step(0, 0, 1, 0, 2'b11, 2'b11, 32'h42);
    chk("T4 skid count", 64'(count_o), 64'd2);
    step(0, 1, 1, 0, 2'b11, 2'b11, 32'hD);
    chk("T4 valid_o", 64'(valid_o), 64'd0);
    chk("T4 count_o", 64'(count_o), 64'd0);
    chk("T4 ready_o", 64'(ready_o), 64'd1);
    chk("T4 WB_o", 64'(WB_o), 64'd0);
    step(0, 0, 0, 1, 2'b00, 2'b00, 32'h0);
    chk("T4 no 0xD", 64'(valid_o), 64'd0);
    step(0, 0, 0, 1, 2'b00, 2'b00, 32'h0);

    // T5: control field mapping
    step(0, 0, 1, 1, 2'b00, 2'b01, 32'h51);
    chk("T5 MemRead rd", 64'(MemRead_o), 64'd1);
    chk("T5 MemWrite rd", 64'(MemWrite_o), 64'd0);
    step(0, 0, 1, 1, 2'b00, 2'b10, 32'h52);
    chk("T5 MemRead wr", 64'(MemRead_o), 64'd0);
    chk("T5 MemWrite wr", 64'(MemWrite_o), 64'd1);
    step(0, 0, 1, 1, 2'b10, 2'b00, 32'h53);
    chk("T5 WB_o", 64'(WB_o), 64'h2);
    step(0, 0, 0, 1, 2'b00, 2'b00, 32'h0);

    // T6: reset and flush together while FULL and draining
    step(0, 0, 1, 1, 2'b11, 2'b11, 32'h61);
    chk("T6 full", 64'(count_o), 64'd1);
    step(1, 1, 1, 1, 2'b11, 2'b11, 32'h62);
    chk("T6 valid_o", 64'(valid_o), 64'd0);
    chk("T6 count_o", 64'(count_o), 64'd0);
    chk("T6 RegData_o", 64'(RegData_o), 64'd0);
    chk("T6 MemData_o", 64'(MemData_o), 64'd0);
    step(0, 0, 0, 1, 2'b00, 2'b00, 32'h0);
    chk("T6 no beat", 64'(valid_o), 64'd0);

    // Mixed valid/ready patterns exercising every transition against the model
    vpat = 24'b1101_1110_0111_1011_0110_1111;
    rpat = 24'b0110_0011_1100_1010_1001_0001;
    for (int i = 0; i < 24; i++) begin
      step(0, (i == 17), vpat[i], rpat[i], WB_W'(i), M_W'(i >> 2), 32'h100 + 32'(i));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 2'b00, 2'b00, 32'h0);
    chk("final empty", 64'(count_o), 64'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
